// File: rtl/drive_ramp_pkg.sv
// rtl/drive_ramp_pkg.sv - shared types and constants for the drive ramp controller
// Purpose: channel/scheduler state encodings, dead-time counter width and
//          channel-index constants used by drive_ramp_controller.
// Ports:   none (package).
package drive_ramp_pkg;

    typedef enum logic [1:0] {
        CH_RUN   = 2'd0,
        CH_DRAIN = 2'd1,
        CH_DEAD  = 2'd2
    } ch_state_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN0 = 3'd1,
        S_SCAN1 = 3'd2,
        S_SCAN2 = 3'd3,
        S_SCAN3 = 3'd4
    } sched_state_t;

    // Dead-time counter width for the default dead time; the top widens it
    // if instantiated with a longer dead time.
    localparam int DEADTIME_DEF = 5;
    localparam int DEAD_W       = $clog2(DEADTIME_DEF + 1);

    localparam logic [1:0] CH0 = 2'd0;
    localparam logic [1:0] CH1 = 2'd1;
    localparam logic [1:0] CH2 = 2'd2;
    localparam logic [1:0] CH3 = 2'd3;

endpackage

// File: rtl/ramp_tick_gen.sv
// rtl/ramp_tick_gen.sv - ramp prescaler producing one tick per RAMP_DIV clocks
// Purpose: counts 0..RAMP_DIV-1 and flags the terminal count.
// Ports:   clk     - system clock
//          reset_n - asynchronous active-low reset
//          tick_o  - high for the one cycle the counter sits at RAMP_DIV-1
module ramp_tick_gen #(
    parameter int RAMP_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick_o
);

    localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(RAMP_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/drive_ramp_controller.sv
// rtl/drive_ramp_controller.sv - slew-limited 4-channel brushed motor command sequencer
// Purpose: accepts per-channel magnitude/direction commands, ramps each channel
//          through one shared add/sub unit on a time-multiplexed scan, forces
//          reversals through zero plus a dead time, and applies obstacle-stop
//          (forward channels only) and e-stop.
// Ports:   clk, reset_n                      - clock, async active-low reset
//          cmd_valid/cmd_ready/cmd_ch/cmd_dir/cmd_mag - command handshake
//          estop                             - level emergency stop
//          sonar_valid/sonar_dist/stop_dist  - obstacle detection inputs
//          mag_out/dir_out                   - per-channel PWM magnitude/direction
//          busy                              - channel not settled on its target
//          obstacle_stop                     - obstacle latch
//          obstacle_events                   - saturating count of obstacle latch
//                                              rising edges (DRIVE_RAMP_EVENT_CNT_EN)
module drive_ramp_controller
    import drive_ramp_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int MAG_W    = 8,
    parameter int RAMP_DIV = 50000,
    parameter int STEP     = 4,
    parameter int DEADTIME = 5,
    parameter int DIST_W   = 16,
    parameter int HYST     = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_ch,
    input  logic                    cmd_dir,
    input  logic [MAG_W-1:0]        cmd_mag,
    input  logic                    estop,
    input  logic                    sonar_valid,
    input  logic [DIST_W-1:0]       sonar_dist,
    input  logic [DIST_W-1:0]       stop_dist,
    output logic [NUM_CH*MAG_W-1:0] mag_out,
    output logic [NUM_CH-1:0]       dir_out,
    output logic [NUM_CH-1:0]       busy,
`ifdef DRIVE_RAMP_EVENT_CNT_EN
    output logic [15:0]             obstacle_events,
`endif
    output logic                    obstacle_stop
);

    localparam int DW = ($clog2(DEADTIME + 1) > DEAD_W) ? $clog2(DEADTIME + 1) : DEAD_W;
    localparam logic [DW-1:0]    DEAD_INIT = DW'(DEADTIME);
    localparam logic [MAG_W:0]   STEP_X    = (MAG_W + 1)'(STEP);
    localparam logic [DIST_W:0]  HYST_X    = (DIST_W + 1)'(HYST);

    logic [MAG_W-1:0]  mag_q     [NUM_CH];
    logic [MAG_W-1:0]  tgt_mag_q [NUM_CH];
    logic [MAG_W-1:0]  eff       [NUM_CH];
    ch_state_t         st_q      [NUM_CH];
    logic [DW-1:0]     dead_q    [NUM_CH];
    logic [NUM_CH-1:0] dir_q;
    logic [NUM_CH-1:0] tgt_dir_q;
    logic              obs_q, obs_d;
    logic              rdy_q;
    logic              tick;
    sched_state_t      sched_q, sched_d;

    ramp_tick_gen #(.RAMP_DIV(RAMP_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick_o  (tick)
    );

    // ready is held low until the first clock after reset release
    assign cmd_ready = rdy_q & ~estop;

    // ---------------- scheduler FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sched_q <= S_IDLE;
        end else begin
            sched_q <= sched_d;
        end
    end

    always_comb begin
        sched_d = sched_q;
        case (sched_q)
            S_IDLE:  if (tick) sched_d = S_SCAN0;
            S_SCAN0: sched_d = S_SCAN1;
            S_SCAN1: sched_d = S_SCAN2;
            S_SCAN2: sched_d = S_SCAN3;
            S_SCAN3: sched_d = S_IDLE;
            default: sched_d = S_IDLE;
        endcase
        if (estop) begin
            sched_d = S_IDLE;
        end
    end

    logic       scan_en;
    logic [1:0] idx;

    always_comb begin
        scan_en = 1'b1;
        idx     = CH0;
        case (sched_q)
            S_SCAN0: idx = CH0;
            S_SCAN1: idx = CH1;
            S_SCAN2: idx = CH2;
            S_SCAN3: idx = CH3;
            default: scan_en = 1'b0;
        endcase
    end

    // ---------------- effective targets and busy ----------------
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            eff[k]  = (obs_q && tgt_dir_q[k]) ? '0 : tgt_mag_q[k];
            busy[k] = (st_q[k] != CH_RUN) || (mag_q[k] != eff[k]);
        end
    end

    // ---------------- shared per-channel update ----------------
    logic [MAG_W-1:0] cur_mag, cur_eff, new_mag;
    logic             cur_dir, cur_tdir, new_dir;
    ch_state_t        cur_st, new_st;
    logic [DW-1:0]    cur_dead, new_dead;
    logic             sub_sel;
    logic [MAG_W:0]   alu;

    always_comb begin
        cur_mag  = mag_q[idx];
        cur_eff  = eff[idx];
        cur_dir  = dir_q[idx];
        cur_tdir = tgt_dir_q[idx];
        cur_st   = st_q[idx];
        cur_dead = dead_q[idx];

        // one adder/subtractor, MAG_W+1 bits so carry/borrow is visible for saturation
        sub_sel = (cur_st != CH_RUN) || (cur_mag > cur_eff);
        alu     = sub_sel ? ({1'b0, cur_mag} - STEP_X) : ({1'b0, cur_mag} + STEP_X);

        new_mag  = cur_mag;
        new_dir  = cur_dir;
        new_st   = cur_st;
        new_dead = cur_dead;

        case (cur_st)
            CH_RUN: begin
                if (cur_tdir != cur_dir) begin
                    if (cur_mag != '0) begin
                        new_st = CH_DRAIN;
                    end else begin
                        new_st   = CH_DEAD;
                        new_dead = DEAD_INIT;
                    end
                end else if (cur_mag < cur_eff) begin
                    new_mag = (alu > {1'b0, cur_eff}) ? cur_eff : alu[MAG_W-1:0];
                end else if (cur_mag > cur_eff) begin
                    new_mag = (alu[MAG_W] || (alu[MAG_W-1:0] < cur_eff)) ? cur_eff : alu[MAG_W-1:0];
                end
            end
            CH_DRAIN: begin
                if (cur_tdir == cur_dir) begin
                    new_st = CH_RUN;
                end else begin
                    new_mag = alu[MAG_W] ? '0 : alu[MAG_W-1:0];
                    if (new_mag == '0) begin
                        new_st   = CH_DEAD;
                        new_dead = DEAD_INIT;
                    end
                end
            end
            CH_DEAD: begin
                new_mag = '0;
                if (cur_dead <= DW'(1)) begin
                    new_dead = '0;
                    new_dir  = ~cur_dir;
                    new_st   = CH_RUN;
                end else begin
                    new_dead = cur_dead - 1'b1;
                end
            end
            default: new_st = CH_RUN;
        endcase
    end

    // ---------------- obstacle latch ----------------
    logic [DIST_W:0] clr_thr;

    always_comb begin
        clr_thr = {1'b0, stop_dist} + HYST_X;
        obs_d   = obs_q;
        if (sonar_valid) begin
            if (sonar_dist < stop_dist) begin
                obs_d = 1'b1;
            end else if ({1'b0, sonar_dist} >= clr_thr) begin
                obs_d = 1'b0;
            end
        end
    end

    // ---------------- channel state ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                mag_q[k]     <= '0;
                tgt_mag_q[k] <= '0;
                st_q[k]      <= CH_RUN;
                dead_q[k]    <= '0;
            end
            dir_q     <= '1;
            tgt_dir_q <= '1;
            obs_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            obs_q <= obs_d;
            if (estop) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    mag_q[k]     <= '0;
                    tgt_mag_q[k] <= '0;
                    st_q[k]      <= CH_RUN;
                end
            end else begin
                // the scan reads the pre-accept target, so a same-slot command waits a tick
                if (scan_en) begin
                    mag_q[idx]  <= new_mag;
                    dir_q[idx]  <= new_dir;
                    st_q[idx]   <= new_st;
                    dead_q[idx] <= new_dead;
                end
                if (cmd_valid && cmd_ready) begin
                    tgt_mag_q[cmd_ch] <= cmd_mag;
                    tgt_dir_q[cmd_ch] <= cmd_dir;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_mag
        assign mag_out[k*MAG_W +: MAG_W] = mag_q[k];
    end

    assign dir_out       = dir_q;
    assign obstacle_stop = obs_q;

`ifdef DRIVE_RAMP_EVENT_CNT_EN
    logic [15:0] evt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_q <= '0;
        end else if (obs_d && !obs_q && (evt_q != 16'hFFFF)) begin
            evt_q <= evt_q + 16'd1;
        end
    end

    assign obstacle_events = evt_q;
`endif

endmodule

// File: tb/tb_drive_ramp_controller.sv
// tb/tb_drive_ramp_controller.sv - directed self-checking bench for drive_ramp_controller
module tb_drive_ramp_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_ch;
    logic        cmd_dir;
    logic [7:0]  cmd_mag;
    logic        estop;
    logic        sonar_valid;
    logic [15:0] sonar_dist;
    logic [15:0] stop_dist;
    logic [31:0] mag_out;
    logic [3:0]  dir_out;
    logic [3:0]  busy;
    logic        obstacle_stop;
`ifdef DRIVE_RAMP_EVENT_CNT_EN
    logic [15:0] obstacle_events;
`endif

    int checks = 0;
    int errors = 0;
    int cyc;

    int exp_rev_mag [7] = '{8, 4, 0, 0, 0, 4, 8};
    int exp_rev_dir [7] = '{1, 1, 1, 1, 0, 0, 0};

    always #5 clk = ~clk;

    drive_ramp_controller #(
        .NUM_CH   (4),
        .MAG_W    (8),
        .RAMP_DIV (8),
        .STEP     (4),
        .DEADTIME (2),
        .DIST_W   (16),
        .HYST     (32)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_ch          (cmd_ch),
        .cmd_dir         (cmd_dir),
        .cmd_mag         (cmd_mag),
        .estop           (estop),
        .sonar_valid     (sonar_valid),
        .sonar_dist      (sonar_dist),
        .stop_dist       (stop_dist),
        .mag_out         (mag_out),
        .dir_out         (dir_out),
        .busy            (busy),
`ifdef DRIVE_RAMP_EVENT_CNT_EN
        .obstacle_events (obstacle_events),
`endif
        .obstacle_stop   (obstacle_stop)
    );

    // clocks since reset release; tick lands on edges where cyc%8==0,
    // channel k refreshes on the edge where cyc%8==k+1
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mag_of(input int k);
        return mag_out[k*8 +: 8];
    endfunction

    task automatic wait_ph(input int p);
        do begin
            @(posedge clk);
            #1;
        end while ((cyc % 8) != p);
    endtask

    task automatic send(input int ch, input logic dir, input int mag);
        cmd_valid = 1'b1;
        cmd_ch    = 2'(ch);
        cmd_dir   = dir;
        cmd_mag   = 8'(mag);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic sonar(input int d);
        sonar_valid = 1'b1;
        sonar_dist  = 16'(d);
        @(posedge clk);
        #1;
        sonar_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_ch      = 2'd0;
        cmd_dir     = 1'b1;
        cmd_mag     = 8'd0;
        estop       = 1'b0;
        sonar_valid = 1'b0;
        sonar_dist  = 16'd0;
        stop_dist   = 16'd100;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_mag", mag_out, 32'd0);
        check("rst_dir", dir_out, 4'hF);
        check("rst_busy", busy, 4'h0);
        check("rst_obs", obstacle_stop, 1'b0);
        check("rst_ready", cmd_ready, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", cmd_ready, 1'b1);

        // ramp up ch1 to 10
        send(1, 1'b1, 10);
        wait_ph(1);
        check("up_ch1_not_yet", mag_of(1), 8'd0);
        wait_ph(2);
        check("up_ch1_4", mag_of(1), 8'd4);
        check("up_busy1", busy[1], 1'b1);
        wait_ph(2);
        check("up_ch1_8", mag_of(1), 8'd8);
        wait_ph(2);
        check("up_ch1_10", mag_of(1), 8'd10);
        check("up_busy1_done", busy[1], 1'b0);
        check("up_vector", mag_out, 32'h0000_0A00);

        // reversal on ch0
        wait_ph(4);
        send(0, 1'b1, 8);
        wait_ph(1);
        check("rev_pre_4", mag_of(0), 8'd4);
        wait_ph(1);
        check("rev_pre_8", mag_of(0), 8'd8);
        wait_ph(4);
        send(0, 1'b0, 8);
        for (int i = 0; i < 7; i++) begin
            wait_ph(1);
            check("rev_mag", mag_of(0), 32'(exp_rev_mag[i]));
            check("rev_dir", dir_out[0], 32'(exp_rev_dir[i]));
            if (i == 0) check("rev_busy", busy[0], 1'b1);
        end
        check("rev_busy_done", busy[0], 1'b0);

        // obstacle: ch2 forward, ch3 reverse
        wait_ph(4);
        send(2, 1'b1, 20);
        send(3, 1'b0, 20);
        repeat (8) wait_ph(4);
        check("obs_ch2_20", mag_of(2), 8'd20);
        check("obs_ch3_20", mag_of(3), 8'd20);
        check("obs_dir3", dir_out[3], 1'b0);
        sonar(100);
        check("obs_at_thr", obstacle_stop, 1'b0);
        sonar(50);
        check("obs_set", obstacle_stop, 1'b1);
        wait_ph(4);
        check("obs_ch2_16", mag_of(2), 8'd16);
        repeat (4) wait_ph(4);
        check("obs_ch2_0", mag_of(2), 8'd0);
        check("obs_ch3_hold", mag_of(3), 8'd20);
        check("obs_busy2", busy[2], 1'b0);
        sonar(120);
        check("obs_hold_120", obstacle_stop, 1'b1);
        sonar(131);
        check("obs_hold_131", obstacle_stop, 1'b1);
        sonar(132);
        check("obs_clear_132", obstacle_stop, 1'b0);
        repeat (5) wait_ph(4);
        check("obs_ch2_back", mag_of(2), 8'd20);

        // command to ch0 during its own scan slot
        wait_ph(0);
        cmd_valid = 1'b1;
        cmd_ch    = 2'd0;
        cmd_dir   = 1'b0;
        cmd_mag   = 8'd0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("sim_old_target", mag_of(0), 8'd8);
        wait_ph(1);
        check("sim_new_target", mag_of(0), 8'd4);

        // back-to-back commands to ch3
        wait_ph(4);
        send(3, 1'b0, 8);
        send(3, 1'b0, 12);
        wait_ph(4);
        check("b2b_16", mag_of(3), 8'd16);
        repeat (2) wait_ph(4);
        check("b2b_last_wins", mag_of(3), 8'd12);

        // e-stop mid-ramp
        wait_ph(4);
        send(1, 1'b1, 40);
        wait_ph(4);
        check("es_mid_14", mag_of(1), 8'd14);
        estop = 1'b1;
        #1;
        check("es_ready", cmd_ready, 1'b0);
        @(posedge clk);
        #1;
        check("es_mag_zero", mag_out, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("es_mag_held", mag_out, 32'd0);
        check("es_dir_kept", dir_out, 4'b0110);
        estop = 1'b0;
        #1;
        check("es_ready_back", cmd_ready, 1'b1);
        repeat (2) wait_ph(4);
        check("es_targets_cleared", mag_out, 32'd0);
        send(1, 1'b1, 8);
        wait_ph(4);
        check("es_restart_4", mag_of(1), 8'd4);

        // async reset while ch1 is in dead time
        send(1, 1'b0, 0);
        wait_ph(4);
        check("dead_drain_4", mag_of(1), 8'd4);
        check("dead_busy", busy[1], 1'b1);
        wait_ph(4);
        check("dead_zero", mag_of(1), 8'd0);
        check("dead_dir_held", dir_out[1], 1'b1);
        sonar(10);
        check("dead_obs_set", obstacle_stop, 1'b1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_mag", mag_out, 32'd0);
        check("arst_dir", dir_out, 4'hF);
        check("arst_busy", busy, 4'h0);
        check("arst_obs", obstacle_stop, 1'b0);
        check("arst_ready", cmd_ready, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
